// File: rtl/parking_gate_controller.sv
// Free-space counter and entry-barrier sequencer for a single-lane car park.
// One car is handled at a time. The barrier closes when the car has passed or when the wait times out.
//
// state   | meaning
// IDLE    | barrier closed, waiting for entry_grant
// OPEN    | barrier open, waiting for car_passed or timeout
// CLOSING | barrier closed for one guaranteed cycle before next entry
module parking_gate_controller #(
  parameter logic [7:0] CAPACITY_MAX = 8'd200,
  parameter int         GATE_TIMEOUT = 16,
  parameter int         TMR_W        = 5
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       entry_grant,
  input  logic       car_passed,
  input  logic       exit_req,
  output logic [7:0] parking_capacity,
  output logic       gate_open,
  output logic       busy,
  output logic       full,
  output logic       timeout_err,
  output logic       exit_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    CLOSING = 2'd2
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [7:0]         cap_q, cap_d;
  logic               gate_q, gate_d;
  logic               tout_q, tout_d;
  logic               exerr_q, exerr_d;
  logic               dec, inc;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cap_q   <= CAPACITY_MAX;
      gate_q  <= 1'b0;
      tout_q  <= 1'b0;
      exerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cap_q   <= cap_d;
      gate_q  <= gate_d;
      tout_q  <= tout_d;
      exerr_q <= exerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dec     = 1'b0;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (entry_grant) begin
          state_d = OPEN;
          timer_d = '0;
        end
      end
      OPEN: begin
        timer_d = timer_q + 1'b1;
        // A pass on the final timeout cycle still counts as a pass.
        if (car_passed) begin
          state_d = CLOSING;
          dec     = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          state_d = CLOSING;
          tout_d  = 1'b1;
        end
      end
      CLOSING: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inc     = exit_req && (cap_q < CAPACITY_MAX);
    exerr_d = exit_req && (cap_q == CAPACITY_MAX);
    gate_d  = (state_d == OPEN);
    cap_d   = cap_q;
    if (dec && !inc) begin
      cap_d = (cap_q == 8'd0) ? 8'd0 : cap_q - 8'd1;
    end else if (inc && !dec) begin
      cap_d = cap_q + 8'd1;
    end
  end

  assign parking_capacity = cap_q;
  assign gate_open        = gate_q;
  assign busy             = (state_q != IDLE);
  assign full             = (cap_q == 8'd0);
  assign timeout_err      = tout_q;
  assign exit_err         = exerr_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench: the driver queues the expected post-edge outputs for each vector.
// A monitor pops each entry one step after the clock edge and compares it with the DUT outputs.
module tb_parking_gate_controller;

  logic clk = 1'b0;
  logic nrst;
  logic a_grant, a_pass, a_exit;
  logic b_grant, b_pass, b_exit;
  logic [7:0] a_cap, b_cap;
  logic a_gate, a_busy, a_full, a_to, a_ee;
  logic b_gate, b_busy, b_full, b_to, b_ee;

  always #5 clk = ~clk;

  parking_gate_controller #(.CAPACITY_MAX(8'd200), .GATE_TIMEOUT(16), .TMR_W(5)) dut_a (
    .clk(clk), .nrst(nrst), .entry_grant(a_grant), .car_passed(a_pass), .exit_req(a_exit),
    .parking_capacity(a_cap), .gate_open(a_gate), .busy(a_busy), .full(a_full),
    .timeout_err(a_to), .exit_err(a_ee));

  parking_gate_controller #(.CAPACITY_MAX(8'd2), .GATE_TIMEOUT(16), .TMR_W(5)) dut_b (
    .clk(clk), .nrst(nrst), .entry_grant(b_grant), .car_passed(b_pass), .exit_req(b_exit),
    .parking_capacity(b_cap), .gate_open(b_gate), .busy(b_busy), .full(b_full),
    .timeout_err(b_to), .exit_err(b_ee));

  typedef struct {
    int         sel;
    logic [12:0] vec;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Monitor: one queued expectation per clock edge driven by the stimulus.
  initial begin
    exp_t e;
    logic [12:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel == 0) act = {a_cap, a_gate, a_busy, a_full, a_to, a_ee};
        else            act = {b_cap, b_gate, b_busy, b_full, b_to, b_ee};
        total++;
        if (act !== e.vec) begin
          bad++;
          $display("FAIL %s: got cap=%0d gate/busy/full/to/ee=%b, want cap=%0d gate/busy/full/to/ee=%b",
                   e.nm, act[12:5], act[4:0], e.vec[12:5], e.vec[4:0]);
        end
      end
    end
  end

  task automatic st(input int sel, input logic rn, input logic g, input logic p, input logic x,
                    input logic [7:0] cap, input logic go, input logic bs, input logic fl,
                    input logic to, input logic ee, input string nm);
    exp_t e;
    nrst = rn;
    a_grant = 1'b0; a_pass = 1'b0; a_exit = 1'b0;
    b_grant = 1'b0; b_pass = 1'b0; b_exit = 1'b0;
    if (sel == 0) begin a_grant = g; a_pass = p; a_exit = x; end
    else          begin b_grant = g; b_pass = p; b_exit = x; end
    e.sel = sel;
    e.vec = {cap, go, bs, fl, to, ee};
    e.nm  = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Full entry cycle on dut A starting from capacity c: open, pass, closing->idle.
  task automatic entry_a(input int c);
    st(0, 1, 1, 0, 0, 8'(c),     1, 1, 0, 0, 0, "ent_open");
    st(0, 1, 0, 1, 0, 8'(c - 1), 0, 1, 0, 0, 0, "ent_pass");
    st(0, 1, 0, 0, 0, 8'(c - 1), 0, 0, 0, 0, 0, "ent_idle");
  endtask

  initial begin
    int cap;
    nrst = 1'b0;
    a_grant = 1'b0; a_pass = 1'b0; a_exit = 1'b0;
    b_grant = 1'b0; b_pass = 1'b0; b_exit = 1'b0;
    @(negedge clk);

    // reset
    st(0, 0, 0, 0, 0, 8'd200, 0, 0, 0, 0, 0, "reset_a0");
    st(0, 0, 0, 0, 0, 8'd200, 0, 0, 0, 0, 0, "reset_a1");
    st(1, 1, 0, 0, 0, 8'd2,   0, 0, 0, 0, 0, "reset_b");

    // normal entry; grant in CLOSING and pass in IDLE are ignored
    st(0, 1, 1, 0, 0, 8'd200, 1, 1, 0, 0, 0, "norm_c0");
    st(0, 1, 0, 0, 0, 8'd200, 1, 1, 0, 0, 0, "norm_c1");
    st(0, 1, 0, 0, 0, 8'd200, 1, 1, 0, 0, 0, "norm_c2");
    st(0, 1, 0, 1, 0, 8'd199, 0, 1, 0, 0, 0, "norm_pass");
    st(0, 1, 1, 0, 0, 8'd199, 0, 0, 0, 0, 0, "grant_in_closing");
    st(0, 1, 0, 1, 0, 8'd199, 0, 0, 0, 0, 0, "pass_in_idle");

    // timeout with grant held high throughout
    st(0, 0, 0, 0, 0, 8'd200, 0, 0, 0, 0, 0, "reset_t");
    st(0, 1, 1, 0, 0, 8'd200, 1, 1, 0, 0, 0, "to_open");
    for (int i = 1; i <= 15; i++) st(0, 1, 1, 0, 0, 8'd200, 1, 1, 0, 0, 0, "to_wait");
    st(0, 1, 1, 0, 0, 8'd200, 0, 1, 0, 1, 0, "to_fire");
    st(0, 1, 0, 0, 0, 8'd200, 0, 0, 0, 0, 0, "to_clear");

    // fill down to 150, then simultaneous pass + exit
    for (int c = 200; c > 150; c--) entry_a(c);
    st(0, 1, 1, 0, 0, 8'd150, 1, 1, 0, 0, 0, "sim_open");
    st(0, 1, 0, 1, 1, 8'd150, 0, 1, 0, 0, 0, "sim_pass_exit");
    st(0, 1, 0, 0, 0, 8'd150, 0, 0, 0, 0, 0, "sim_idle");
    cap = 150;
    while (cap < 200) begin
      cap++;
      st(0, 1, 0, 0, 1, 8'(cap), 0, 0, 0, 0, 0, "exit_inc");
    end
    st(0, 1, 0, 0, 1, 8'd200, 0, 0, 0, 0, 1, "exit_at_max");
    st(0, 1, 0, 0, 0, 8'd200, 0, 0, 0, 0, 0, "exit_err_clear");

    // reset while open restores capacity
    entry_a(200);
    st(0, 1, 1, 0, 0, 8'd199, 1, 1, 0, 0, 0, "mid_open");
    st(0, 1, 0, 0, 0, 8'd199, 1, 1, 0, 0, 0, "mid_hold");
    st(0, 0, 0, 1, 0, 8'd200, 0, 0, 0, 0, 0, "mid_reset");
    st(0, 1, 0, 0, 0, 8'd200, 0, 0, 0, 0, 0, "mid_after");

    // pass on the last timeout cycle wins over timeout
    st(0, 1, 1, 0, 0, 8'd200, 1, 1, 0, 0, 0, "pri_open");
    for (int i = 1; i <= 15; i++) st(0, 1, 0, 0, 0, 8'd200, 1, 1, 0, 0, 0, "pri_wait");
    st(0, 1, 0, 1, 0, 8'd199, 0, 1, 0, 0, 0, "pri_pass");
    st(0, 1, 0, 0, 0, 8'd199, 0, 0, 0, 0, 0, "pri_idle");

    // small lot: fill, saturate at zero, exit
    st(1, 1, 1, 0, 0, 8'd2, 1, 1, 0, 0, 0, "b_open1");
    st(1, 1, 0, 1, 0, 8'd1, 0, 1, 0, 0, 0, "b_pass1");
    st(1, 1, 0, 0, 0, 8'd1, 0, 0, 0, 0, 0, "b_idle1");
    st(1, 1, 1, 0, 0, 8'd1, 1, 1, 0, 0, 0, "b_open2");
    st(1, 1, 0, 1, 0, 8'd0, 0, 1, 1, 0, 0, "b_full");
    st(1, 1, 0, 0, 0, 8'd0, 0, 0, 1, 0, 0, "b_idle2");
    st(1, 1, 1, 0, 0, 8'd0, 1, 1, 1, 0, 0, "b_open3");
    st(1, 1, 0, 1, 0, 8'd0, 0, 1, 1, 0, 0, "b_sat_zero");
    st(1, 1, 0, 0, 0, 8'd0, 0, 0, 1, 0, 0, "b_idle3");
    st(1, 1, 0, 0, 1, 8'd1, 0, 0, 0, 0, 0, "b_exit");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
